// File: rtl/sgm_div_arbiter.sv
// Round-robin front end for one shared pipelined SRT4 divider.
// Issues at most one division per enabled cycle, tracks each issue through a
// tag pipe matched to the divider latency, returns quotients to the owning
// requester, saturates divide-by-zero and flags tag/valid misalignment.
module sgm_div_arbiter #(
    parameter int N_REQ = 4,
    parameter int LAT   = 17,
    parameter int IDW   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*11-1:0]  req_x,
    input  logic [N_REQ*11-1:0]  req_d,
    input  logic [N_REQ-1:0]     req_f,
    output logic                 div_clken,
    output logic                 div_validin,
    output logic [10:0]          div_x,
    output logic [10:0]          div_d,
    output logic                 div_f,
    input  logic [16:0]          div_q,
    input  logic                 div_valid,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [16:0]          rsp_q,
    output logic                 busy,
    output logic                 err
);

    localparam int unsigned NR = N_REQ;
    localparam int unsigned NL = LAT;

    typedef struct packed {
        logic           v;
        logic [IDW-1:0] id;
        logic           dz;
        logic           f;
    } tag_t;

    logic [IDW-1:0] rr;
    logic [IDW-1:0] grant;
    logic           any_valid;
    logic           issue;
    logic           capture;
    logic [5:0]     inflight;
    tag_t           tags [LAT];
    tag_t           tag_head;

    // Round-robin search: first valid requester starting at the rr pointer.
    always_comb begin
        int unsigned    idx;
        logic [IDW-1:0] cand;
        any_valid = 1'b0;
        grant     = '0;
        idx       = 0;
        cand      = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            idx = k + {{(32-IDW){1'b0}}, rr};
            if (idx >= NR) idx = idx - NR;
            cand = idx[IDW-1:0];
            if (!any_valid && req_valid[cand]) begin
                any_valid = 1'b1;
                grant     = cand;
            end
        end
    end

    assign issue       = en & any_valid;
    assign div_validin = issue;
    assign div_clken   = en;
    assign capture     = en & div_valid;
    assign tag_head    = tags[LAT-1];
    assign busy        = (inflight != '0);

    // Route the granted requester's operands to the divider and raise its ready.
    always_comb begin
        req_ready = '0;
        div_x     = '0;
        div_d     = '0;
        div_f     = 1'b0;
        for (int unsigned k = 0; k < NR; k++) begin
            if (issue && (IDW'(k) == grant)) begin
                req_ready[k] = 1'b1;
                div_x        = req_x[11*k +: 11];
                div_d        = req_d[11*k +: 11];
                div_f        = req_f[k];
            end
        end
    end

    // Tag pipe: shadows the divider pipeline, advancing only on enabled cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NL; i++) tags[i] <= '0;
        end else if (en) begin
            tags[0] <= '{v: issue, id: grant, dz: issue & (div_d == '0), f: div_f};
            for (int unsigned i = 1; i < NL; i++) tags[i] <= tags[i-1];
        end
    end

    // Round-robin pointer: moves just past the requester that was served.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr <= '0;
        end else if (issue) begin
            rr <= (grant == IDW'(N_REQ-1)) ? '0 : grant + 1'b1;
        end
    end

    // Result stage: one-cycle pulse to the tagged requester, saturate on /0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid <= '0;
            rsp_q     <= '0;
        end else begin
            rsp_valid <= '0;
            if (capture) begin
                rsp_valid[tag_head.id] <= 1'b1;
                rsp_q <= tag_head.dz ? {tag_head.f, 16'hFFFF} : div_q;
            end
        end
    end

    // In-flight counter: issue and capture in the same cycle cancel out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= '0;
        end else begin
            case ({issue, capture})
                2'b10:   inflight <= inflight + 6'd1;
                2'b01:   inflight <= inflight - 6'd1;
                default: inflight <= inflight;
            endcase
        end
    end

    // Sticky error when divider valid and tag valid disagree at the head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (en && (div_valid ^ tag_head.v)) begin
            err <= 1'b1;
        end
    end

endmodule
